// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
//   state_t      : controller states (IDLE/RUN/PAUSE/DONE)
//   TENS_W/UNITS_W, TENS_MAX/UNITS_MAX : BCD digit widths and limits
//   clamp_tens/clamp_units : saturate an out-of-range preset digit
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int TENS_W  = 3;
    localparam int UNITS_W = 4;

    localparam logic [TENS_W-1:0]  TENS_MAX  = 3'd5;
    localparam logic [UNITS_W-1:0] UNITS_MAX = 4'd9;

    function automatic logic [TENS_W-1:0] clamp_tens(input logic [TENS_W-1:0] v);
        return (v > TENS_MAX) ? TENS_MAX : v;
    endfunction

    function automatic logic [UNITS_W-1:0] clamp_units(input logic [UNITS_W-1:0] v);
        return (v > UNITS_MAX) ? UNITS_MAX : v;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd60_down.sv
// bcd60_down: 0..59 BCD down-counter (tens 0..5, units 0..9).
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_dec               : decrement by one this cycle
//   i_load              : load i_load_tens/i_load_units (wins over i_dec)
//   o_tens, o_units     : current value (registered)
//   o_zero              : value is 00
//   o_bo                : borrow-out, i_dec while value is 00 (wraps to 59)
module bcd60_down
    import countdown_timer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_dec,
    input  logic               i_load,
    input  logic [TENS_W-1:0]  i_load_tens,
    input  logic [UNITS_W-1:0] i_load_units,
    output logic [TENS_W-1:0]  o_tens,
    output logic [UNITS_W-1:0] o_units,
    output logic               o_zero,
    output logic               o_bo
);

    logic [TENS_W-1:0]  r_tens;
    logic [UNITS_W-1:0] r_units;
    logic               w_zero;

    assign w_zero  = (r_tens == '0) && (r_units == '0);
    assign o_zero  = w_zero;
    assign o_bo    = i_dec & w_zero;
    assign o_tens  = r_tens;
    assign o_units = r_units;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tens  <= '0;
            r_units <= '0;
        end else if (i_load) begin
            r_tens  <= i_load_tens;
            r_units <= i_load_units;
        end else if (i_dec) begin
            if (r_units == '0) begin
                r_units <= UNITS_MAX;
                r_tens  <= (r_tens == '0) ? TENS_MAX : r_tens - 3'd1;
            end else begin
                r_units <= r_units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with programmable-length alarm.
//   CLK, RST           : clock, synchronous active-low reset
//   EN                 : 1 Hz tick, one CLK wide
//   LOAD/START/STOP    : control requests, priority STOP > LOAD > START
//   SET_MH..SET_SL     : preset digits (clamped to 5/9 on load)
//   MH, ML, SH, SL     : current value (registered)
//   BUSY               : counting (RUN)
//   ALARM              : terminal count reached (DONE)
//   BO                 : combinational minute borrow strobe
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int ALARM_LEN = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               LOAD,
    input  logic               START,
    input  logic               STOP,
    input  logic [TENS_W-1:0]  SET_MH,
    input  logic [UNITS_W-1:0] SET_ML,
    input  logic [TENS_W-1:0]  SET_SH,
    input  logic [UNITS_W-1:0] SET_SL,
    output logic [TENS_W-1:0]  MH,
    output logic [UNITS_W-1:0] ML,
    output logic [TENS_W-1:0]  SH,
    output logic [UNITS_W-1:0] SL,
    output logic               BUSY,
    output logic               ALARM,
    output logic               BO
);

    state_t     r_state;
    logic [7:0] r_alarm_cnt;
    logic       r_busy;
    logic       r_alarm;

    logic w_run;
    logic w_load_ok;
    logic w_sec_dec;
    logic w_sec_bo;
    logic w_min_bo;
    logic w_sec_zero;
    logic w_min_zero;
    logic w_nonzero;
    logic w_last_tick;

    assign w_run     = (r_state == ST_RUN);
    // STOP masks the lower-priority requests in the same cycle.
    assign w_load_ok = LOAD & ~STOP & ~w_run;
    assign w_sec_dec = EN & w_run & ~STOP;
    assign w_nonzero = ~(w_sec_zero & w_min_zero);

    // RUN never holds 00:00, so the decrement that lands on zero is the one
    // from 00:01; detecting it here lets DONE start on the same edge.
    assign w_last_tick = w_sec_dec & w_min_zero & (SH == '0) & (SL == 4'd1);

    assign BO = EN & w_run & w_sec_zero & ~w_min_zero;

    bcd60_down u_sec (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_dec        (w_sec_dec),
        .i_load       (w_load_ok),
        .i_load_tens  (clamp_tens(SET_SH)),
        .i_load_units (clamp_units(SET_SL)),
        .o_tens       (SH),
        .o_units      (SL),
        .o_zero       (w_sec_zero),
        .o_bo         (w_sec_bo)
    );

    bcd60_down u_min (
        .i_clk        (CLK),
        .i_rst_n      (RST),
        .i_dec        (w_sec_bo),
        .i_load       (w_load_ok),
        .i_load_tens  (clamp_tens(SET_MH)),
        .i_load_units (clamp_units(SET_ML)),
        .o_tens       (MH),
        .o_units      (ML),
        .o_zero       (w_min_zero),
        .o_bo         (w_min_bo)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_alarm_cnt <= '0;
            r_busy      <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!STOP && !LOAD && START && w_nonzero) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        r_state <= ST_PAUSE;
                        r_busy  <= 1'b0;
                    end else if (w_last_tick) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_alarm     <= 1'b1;
                        r_alarm_cnt <= '0;
                    end
                end
                ST_PAUSE: begin
                    if (STOP) begin
                        r_state <= ST_PAUSE;
                    end else if (LOAD) begin
                        r_state     <= ST_IDLE;
                        r_alarm_cnt <= '0;
                    end else if (START && w_nonzero) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (STOP || LOAD) begin
                        r_state     <= ST_IDLE;
                        r_alarm     <= 1'b0;
                        r_alarm_cnt <= '0;
                    end else if (EN) begin
                        if (r_alarm_cnt == 8'(ALARM_LEN - 1)) begin
                            r_state     <= ST_IDLE;
                            r_alarm     <= 1'b0;
                            r_alarm_cnt <= '0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY  = r_busy;
    assign ALARM = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer. Each step pushes the expected
// post-edge state {MH,ML,SH,SL,BUSY,ALARM} to a scoreboard queue, drives one
// cycle, then pops and compares. BO is checked combinationally mid-cycle.
module tb_countdown_timer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0, LOAD = 1'b0, START = 1'b0, STOP = 1'b0;
    logic [2:0] SET_MH = '0, SET_SH = '0;
    logic [3:0] SET_ML = '0, SET_SL = '0;
    logic [2:0] MH, SH;
    logic [3:0] ML, SL;
    logic       BUSY, ALARM, BO;

    countdown_timer #(.ALARM_LEN(10)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .START(START), .STOP(STOP),
        .SET_MH(SET_MH), .SET_ML(SET_ML), .SET_SH(SET_SH), .SET_SL(SET_SL),
        .MH(MH), .ML(ML), .SH(SH), .SL(SL),
        .BUSY(BUSY), .ALARM(ALARM), .BO(BO)
    );

    always #5 CLK = ~CLK;

    // control word {rst, en, load, start, stop}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_RST  = 5'b10000;
    localparam logic [4:0] C_EN   = 5'b01000;
    localparam logic [4:0] C_LD   = 5'b00100;
    localparam logic [4:0] C_ST   = 5'b00010;
    localparam logic [4:0] C_SP   = 5'b00001;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_preset(input int mh, input int ml, input int sh, input int sl);
        SET_MH = 3'(mh); SET_ML = 4'(ml); SET_SH = 3'(sh); SET_SL = 4'(sl);
    endtask

    // Called #1 after a rising edge; drives c for one cycle.
    task automatic step(input logic [4:0] c, input string tag,
                        input int emh, input int eml, input int esh, input int esl,
                        input logic eb, input logic ea, input logic ebo);
        exp_t e;
        e.tag = tag;
        e.v   = {3'(emh), 4'(eml), 3'(esh), 4'(esl), eb, ea};
        exp_q.push_back(e);
        RST = ~c[4]; EN = c[3]; LOAD = c[2]; START = c[1]; STOP = c[0];
        #2;
        chk({tag, "/bo"}, 16'(BO), 16'(ebo));
        @(posedge CLK);
        #1;
        RST = 1'b1; EN = 1'b0; LOAD = 1'b0; START = 1'b0; STOP = 1'b0;
        e = exp_q.pop_front();
        chk(e.tag, {MH, ML, SH, SL, BUSY, ALARM}, e.v);
    endtask

    initial begin
        @(posedge CLK); #1;
        step(C_RST, "reset", 0,0,0,0, 0,0, 0);

        // reset mid-RUN
        set_preset(0,1,0,5);
        step(C_LD,  "rr_load",  0,1,0,5, 0,0, 0);
        step(C_ST,  "rr_start", 0,1,0,5, 1,0, 0);
        step(C_EN,  "rr_en1",   0,1,0,4, 1,0, 0);
        step(C_EN,  "rr_en2",   0,1,0,3, 1,0, 0);
        step(C_EN,  "rr_en3",   0,1,0,2, 1,0, 0);
        step(C_RST, "rr_rst",   0,0,0,0, 0,0, 0);
        step(C_EN,  "rr_idle_en", 0,0,0,0, 0,0, 0);
        step(C_ST,  "rr_start0",  0,0,0,0, 0,0, 0);

        // minute borrow chain
        set_preset(1,0,0,0);
        step(C_LD,  "bc_load",  1,0,0,0, 0,0, 0);
        step(C_ST,  "bc_start", 1,0,0,0, 1,0, 0);
        step(C_EN,  "bc_en1",   0,9,5,9, 1,0, 1);
        step(C_EN,  "bc_en2",   0,9,5,8, 1,0, 0);
        step(C_SP,  "bc_stop",  0,9,5,8, 0,0, 0);

        // terminal count and full alarm length (LOAD from PAUSE)
        set_preset(0,0,0,2);
        step(C_LD,  "tc_load",  0,0,0,2, 0,0, 0);
        step(C_ST,  "tc_start", 0,0,0,2, 1,0, 0);
        step(C_EN,  "tc_en1",   0,0,0,1, 1,0, 0);
        step(C_EN,  "tc_done",  0,0,0,0, 0,1, 0);
        for (int i = 0; i < 9; i++)
            step(C_EN, "tc_alarm_hold", 0,0,0,0, 0,1, 0);
        step(C_EN,  "tc_alarm_end", 0,0,0,0, 0,0, 0);
        step(C_EN,  "tc_en11",      0,0,0,0, 0,0, 0);

        // pause / resume
        set_preset(0,0,3,0);
        step(C_LD,  "pr_load",  0,0,3,0, 0,0, 0);
        step(C_ST,  "pr_start", 0,0,3,0, 1,0, 0);
        step(C_EN,  "pr_en1",   0,0,2,9, 1,0, 0);
        step(C_EN,  "pr_en2",   0,0,2,8, 1,0, 0);
        step(C_EN,  "pr_en3",   0,0,2,7, 1,0, 0);
        step(C_EN,  "pr_en4",   0,0,2,6, 1,0, 0);
        step(C_EN,  "pr_en5",   0,0,2,5, 1,0, 0);
        step(C_EN | C_SP, "pr_stop_en", 0,0,2,5, 0,0, 0);
        for (int i = 0; i < 3; i++)
            step(C_EN, "pr_pause_en", 0,0,2,5, 0,0, 0);
        step(C_ST,  "pr_resume", 0,0,2,5, 1,0, 0);
        step(C_EN,  "pr_en6",    0,0,2,4, 1,0, 0);
        step(C_SP,  "pr_stop2",  0,0,2,4, 0,0, 0);

        // load rules
        set_preset(7,12,6,15);
        step(C_LD,  "lr_clamp", 5,9,5,9, 0,0, 0);
        step(C_ST,  "lr_start", 5,9,5,9, 1,0, 0);
        set_preset(0,0,0,1);
        step(C_LD,  "lr_load_run", 5,9,5,9, 1,0, 0);
        step(C_EN,  "lr_en",       5,9,5,8, 1,0, 0);
        step(C_SP,  "lr_stop",     5,9,5,8, 0,0, 0);
        set_preset(0,0,0,0);
        step(C_LD,  "lr_load0",    0,0,0,0, 0,0, 0);
        step(C_ST,  "lr_start0",   0,0,0,0, 0,0, 0);
        set_preset(0,0,0,3);
        step(C_LD | C_ST, "lr_ld_st", 0,0,0,3, 0,0, 0);
        step(C_EN,  "lr_idle_en",  0,0,0,3, 0,0, 0);
        step(C_ST,  "lr_start3",   0,0,0,3, 1,0, 0);
        step(C_EN,  "lr_en2",      0,0,0,2, 1,0, 0);
        step(C_EN,  "lr_en1",      0,0,0,1, 1,0, 0);
        step(C_EN,  "lr_done",     0,0,0,0, 0,1, 0);

        // early silence, then alarm counter restarts from zero
        step(C_EN,  "es_en1",   0,0,0,0, 0,1, 0);
        step(C_EN,  "es_en2",   0,0,0,0, 0,1, 0);
        step(C_SP,  "es_stop",  0,0,0,0, 0,0, 0);
        set_preset(0,0,0,1);
        step(C_LD,  "es_load",  0,0,0,1, 0,0, 0);
        step(C_ST,  "es_start", 0,0,0,1, 1,0, 0);
        step(C_EN,  "es_done",  0,0,0,0, 0,1, 0);
        for (int i = 0; i < 9; i++)
            step(C_EN, "es_alarm_hold", 0,0,0,0, 0,1, 0);
        step(C_EN,  "es_alarm_end", 0,0,0,0, 0,0, 0);

        // reset mid-DONE
        step(C_LD,  "rd_load",  0,0,0,1, 0,0, 0);
        step(C_ST,  "rd_start", 0,0,0,1, 1,0, 0);
        step(C_EN,  "rd_done",  0,0,0,0, 0,1, 0);
        step(C_RST, "rd_rst",   0,0,0,0, 0,0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
